// File: rtl/tdm_demux_8ch.sv
// Receive-side TDM demultiplexer: steers a ch0..ch7 sample stream into per-channel
// slots and publishes all eight channels atomically when a frame completes.
module tdm_demux_8ch #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned GAP_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_valid,
   input  logic                 frame_start,
   output logic [8*WIDTH-1:0]   dout,
   output logic                 frame_done,
   output logic                 frame_err,
   output logic [2:0]           ch_idx,
   output logic                 busy
);

   localparam int unsigned NCH     = 8;
   localparam int unsigned LAST_CH = NCH - 1;
   localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t           state;
   logic [GAP_W-1:0] gap;

   // Shadow slots for ch0..ch6; ch7 never needs storing because it lands in dout directly.
   logic [WIDTH-1:0] shadow [LAST_CH];

   logic [8*WIDTH-1:0] frame_c;
   logic               gap_expire_c;
   logic               last_slot_c;

   // Completed frame as it will be published: buffered slots plus the arriving ch7 sample.
   always_comb begin
      frame_c = '0;
      for (int unsigned k = 0; k < LAST_CH; k++) begin
         frame_c[k*WIDTH +: WIDTH] = shadow[k];
      end
      frame_c[LAST_CH*WIDTH +: WIDTH] = din;
   end

   assign gap_expire_c = (gap == GAP_W'(GAP_MAX - 1));
   assign last_slot_c  = (ch_idx == 3'(LAST_CH));

   // Frame assembly FSM; pulses default low every cycle so they last exactly one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dout       <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         ch_idx     <= 3'd0;
         busy       <= 1'b0;
         gap        <= '0;
         for (int unsigned k = 0; k < LAST_CH; k++) begin
            shadow[k] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         case (state)
            IDLE: begin
               // Samples without a frame marker are stray link data and are dropped silently.
               if (din_valid && frame_start) begin
                  shadow[0] <= din;
                  ch_idx    <= 3'd1;
                  gap       <= '0;
                  busy      <= 1'b1;
                  state     <= COLLECT;
               end
            end

            COLLECT: begin
               if (din_valid && frame_start) begin
                  // Early frame marker: abandon the partial frame and restart on this sample.
                  frame_err <= 1'b1;
                  shadow[0] <= din;
                  ch_idx    <= 3'd1;
                  gap       <= '0;
               end else if (din_valid) begin
                  gap <= '0;
                  if (last_slot_c) begin
                     dout       <= frame_c;
                     frame_done <= 1'b1;
                     ch_idx     <= 3'd0;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     shadow[ch_idx] <= din;
                     ch_idx         <= ch_idx + 3'd1;
                  end
               end else if (gap_expire_c) begin
                  frame_err <= 1'b1;
                  ch_idx    <= 3'd0;
                  gap       <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  gap <= gap + GAP_W'(1);
               end
            end

            default: begin
               state  <= IDLE;
               ch_idx <= 3'd0;
               busy   <= 1'b0;
               gap    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Scoreboard bench for tdm_demux_8ch: stimulus pushes expected pulses/frames,
// a negedge monitor pops and compares whenever frame_done or frame_err fires.
module tb_tdm_demux_8ch;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned GAP_MAX = 16;

   logic                 clk;
   logic                 rst_n;
   logic [WIDTH-1:0]     din;
   logic                 din_valid;
   logic                 frame_start;
   logic [8*WIDTH-1:0]   dout;
   logic                 frame_done;
   logic                 frame_err;
   logic [2:0]           ch_idx;
   logic                 busy;

   typedef struct {
      logic        is_done;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   done_cyc[$];
   int   nvec;
   int   nerr;
   int   cyc_cnt;
   logic [63:0] model_dout;

   tdm_demux_8ch #(.WIDTH(WIDTH), .GAP_MAX(GAP_MAX)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .dout        (dout),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .ch_idx      (ch_idx),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic is_done, input logic [63:0] data);
      exp_t e;
      e.is_done = is_done;
      e.data    = data;
      sb.push_back(e);
   endtask

   // Monitor: every pulse must match the head of the scoreboard, including the dout it shows.
   always @(negedge clk) begin
      if (rst_n) begin
         cyc_cnt++;
         if (frame_done && frame_err) chk("pulse_exclusive", 64'd1, 64'd0);
         if (frame_done || frame_err) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {62'd0, frame_done, frame_err}, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk(e.is_done ? "done_kind" : "err_kind", {63'd0, frame_done}, {63'd0, e.is_done});
               chk(e.is_done ? "done_dout" : "err_dout", dout, e.data);
               if (frame_done) done_cyc.push_back(cyc_cnt);
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic fs, input logic [7:0] d);
      din         = d;
      din_valid   = v;
      frame_start = fs;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
   endtask

   // Full frame b..b+7; optional idle run after slot gap_at; optional resync error on ch0.
   task automatic frame8(input logic [7:0] b, input logic [63:0] e, input int gap_at,
                         input int gap_len, input bit err_first);
      for (int i = 0; i < 8; i++) begin
         if (i == 0 && err_first) push(1'b0, model_dout);
         if (i == 7) push(1'b1, e);
         cyc(1'b1, i == 0, b + 8'(i));
         if (i == gap_at) idle(gap_len);
      end
      model_dout = e;
   endtask

   initial begin
      nvec        = 0;
      nerr        = 0;
      cyc_cnt     = 0;
      model_dout  = 64'd0;
      rst_n       = 1'b1;
      din         = 8'h00;
      din_valid   = 1'b0;
      frame_start = 1'b0;

      // T1: asynchronous reset before any clock edge
      #3 rst_n = 1'b0;
      #1;
      chk("rst_dout", dout, 64'd0);
      chk("rst_done", {63'd0, frame_done}, 64'd0);
      chk("rst_err", {63'd0, frame_err}, 64'd0);
      chk("rst_ch_idx", {61'd0, ch_idx}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // T2: basic frame
      push(1'b1, 64'h1716151413121110);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, i == 0, 8'h10 + 8'(i));
         if (i == 2) begin
            chk("t2_ch_idx_mid", {61'd0, ch_idx}, 64'd3);
            chk("t2_busy_mid", {63'd0, busy}, 64'd1);
         end
      end
      model_dout = 64'h1716151413121110;
      chk("t2_ch_idx_end", {61'd0, ch_idx}, 64'd0);
      chk("t2_busy_end", {63'd0, busy}, 64'd0);
      idle(2);

      // T3: short gap is tolerated; a full GAP_MAX gap aborts the frame
      frame8(8'h10, 64'h1716151413121110, 3, 3, 1'b0);
      idle(1);
      cyc(1'b1, 1'b1, 8'h20);
      cyc(1'b1, 1'b0, 8'h21);
      cyc(1'b1, 1'b0, 8'h22);
      idle(15);
      chk("t3_ch_idx_gap15", {61'd0, ch_idx}, 64'd3);
      chk("t3_busy_gap15", {63'd0, busy}, 64'd1);
      push(1'b0, 64'h1716151413121110);
      idle(1);
      chk("t3_ch_idx_abort", {61'd0, ch_idx}, 64'd0);
      chk("t3_busy_abort", {63'd0, busy}, 64'd0);
      idle(2);

      // T4: resync on a frame marker at ch5
      for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, 8'hB0 + 8'(i));
      chk("t4_ch_idx_pre", {61'd0, ch_idx}, 64'd5);
      frame8(8'hA0, 64'hA7A6A5A4A3A2A1A0, -1, 0, 1'b1);
      idle(2);

      // T5: stray samples in IDLE, then two back-to-back frames
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
      chk("t5_ch_idx_stray", {61'd0, ch_idx}, 64'd0);
      chk("t5_busy_stray", {63'd0, busy}, 64'd0);
      done_cyc.delete();
      frame8(8'h30, 64'h3736353433323130, -1, 0, 1'b0);
      frame8(8'h40, 64'h4746454443424140, -1, 0, 1'b0);
      idle(2);
      if (done_cyc.size() == 2) chk("t5_done_spacing", 64'(done_cyc[1] - done_cyc[0]), 64'd8);
      else chk("t5_done_count", 64'(done_cyc.size()), 64'd2);

      // T6: reset mid-frame, then a clean frame
      for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, 8'h50 + 8'(i));
      din_valid = 1'b0;
      frame_start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_dout", dout, 64'd0);
      chk("t6_rst_ch_idx", {61'd0, ch_idx}, 64'd0);
      chk("t6_rst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("t6_rst_err", {63'd0, frame_err}, 64'd0);
      rst_n = 1'b1;
      model_dout = 64'd0;
      idle(1);
      frame8(8'h60, 64'h6766656463626160, -1, 0, 1'b0);
      idle(3);

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
